// File: rtl/sram_bank_pkg.sv
// Shared types and limits for the multi-bank SRAM back end.
package sram_bank_pkg;

    typedef enum logic [1:0] {
        ACTIVE    = 2'd0,
        RETENTION = 2'd1,
        WAKE      = 2'd2
    } bank_state_e;

    localparam int unsigned MaxReadLatency = 4;

endpackage

// File: rtl/sram_bank_ctrl_bank.sv
// One SRAM bank: retention FSM, idle/wake counters, response pipeline and macro.
module sram_bank_ctrl_bank
    import sram_bank_pkg::*;
#(
    parameter int unsigned WordsPerBank  = 4096,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned ReadLatency   = 1,
    parameter int unsigned IdleThreshold = 64,
    parameter int unsigned WakeCycles    = 4,
    parameter int unsigned BankAddrWidth = $clog2(WordsPerBank)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     ret_en_i,
    input  logic                     req_i,
    output logic                     gnt_o,
    input  logic [BankAddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0]     wdata_i,
    input  logic [DataWidth/8-1:0]   strb_i,
    input  logic                     we_i,
    output logic                     rvalid_o,
    output logic [DataWidth-1:0]     rdata_o,
    output bank_state_e              state_o
);

    localparam int unsigned Latency =
        (ReadLatency > MaxReadLatency) ? MaxReadLatency :
        (ReadLatency == 0)             ? 1 : ReadLatency;
    localparam bit          RetAllowed   = (IdleThreshold != 0);
    localparam int unsigned IdleCntWidth = (IdleThreshold > 1) ? $clog2(IdleThreshold) : 1;
    localparam int unsigned WakeCntWidth = (WakeCycles > 1) ? $clog2(WakeCycles) : 1;
    localparam logic [IdleCntWidth-1:0] IdleMax =
        IdleCntWidth'((IdleThreshold > 0) ? IdleThreshold - 1 : 0);
    localparam logic [WakeCntWidth-1:0] WakeLoad =
        WakeCntWidth'((WakeCycles > 0) ? WakeCycles - 1 : 0);

    bank_state_e             state_q;
    logic [IdleCntWidth-1:0] idle_cnt_q;
    logic [WakeCntWidth-1:0] wake_cnt_q;
    logic [Latency-1:0]      vld_q;
    logic [DataWidth-1:0]    sram_rdata;
    logic                    xfer;
    logic                    pending;
    logic                    idle;

    assign gnt_o   = (state_q == ACTIVE);
    assign xfer    = req_i && gnt_o;
    assign pending = |vld_q;
    assign idle    = !req_i && !pending;
    assign state_o = state_q;

    // Idle counter saturates at the entry threshold so a late ret_en_i still enters retention.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ACTIVE;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
        end else begin
            unique case (state_q)
                ACTIVE: begin
                    if (RetAllowed && ret_en_i && idle && (idle_cnt_q == IdleMax)) begin
                        state_q    <= RETENTION;
                        idle_cnt_q <= '0;
                    end else if (idle) begin
                        if (idle_cnt_q != IdleMax) begin
                            idle_cnt_q <= idle_cnt_q + 1'b1;
                        end
                    end else begin
                        idle_cnt_q <= '0;
                    end
                end
                RETENTION: begin
                    if (req_i || !ret_en_i) begin
                        state_q    <= WAKE;
                        wake_cnt_q <= WakeLoad;
                    end
                end
                WAKE: begin
                    if (wake_cnt_q == '0) begin
                        state_q <= ACTIVE;
                    end else begin
                        wake_cnt_q <= wake_cnt_q - 1'b1;
                    end
                end
                default: state_q <= ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= xfer;
            for (int unsigned i = 1; i < Latency; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign rvalid_o = vld_q[Latency-1];

    // The macro already registers read data once; extra stages cover the remaining latency.
    if (Latency > 1) begin : g_rdata_pipe
        logic [DataWidth-1:0] stage_q [Latency-1];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int unsigned i = 0; i < Latency - 1; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= sram_rdata;
                for (int unsigned i = 1; i < Latency - 1; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign rdata_o = stage_q[Latency-2];
    end else begin : g_rdata_direct
        assign rdata_o = sram_rdata;
    end

    sram_wrapper #(
        .NumWords  (WordsPerBank),
        .DataWidth (DataWidth),
        .AddrWidth (BankAddrWidth)
    ) u_sram (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .req_i            (xfer),
        .we_i             (we_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .be_i             (strb_i),
        .rdata_o          (sram_rdata),
        .set_retentive_ni (state_q != RETENTION),
        .pwrgate_ni       (1'b1)
    );

endmodule

// File: rtl/sram_wrapper.sv
// Single-port byte-enabled SRAM macro wrapper with registered read data.
module sram_wrapper #(
    parameter int unsigned NumWords  = 4096,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = $clog2(NumWords)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] be_i,
    output logic [DataWidth-1:0]   rdata_o,
    input  logic                   set_retentive_ni,
    input  logic                   pwrgate_ni
);

    logic [DataWidth-1:0] mem_q [NumWords];
    logic [DataWidth-1:0] rdata_q;
    logic                 access;

    // The array is only usable while neither retained nor power gated.
    assign access = req_i && set_retentive_ni && pwrgate_ni;

    always_ff @(posedge clk_i) begin
        if (access && we_i) begin
            for (int unsigned i = 0; i < DataWidth / 8; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (access && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_bank_ctrl.sv
// Multi-bank SRAM back end: independent banks with per-bank retention control.
module sram_bank_ctrl
    import sram_bank_pkg::*;
#(
    parameter int unsigned NumBanks      = 2,
    parameter int unsigned WordsPerBank  = 4096,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned ReadLatency   = 1,
    parameter int unsigned IdleThreshold = 64,
    parameter int unsigned WakeCycles    = 4,
    parameter int unsigned BankAddrWidth = $clog2(WordsPerBank)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              ret_en_i,
    input  logic [NumBanks-1:0]               mem_req_i,
    output logic [NumBanks-1:0]               mem_gnt_o,
    input  logic [NumBanks*BankAddrWidth-1:0] mem_addr_i,
    input  logic [NumBanks*DataWidth-1:0]     mem_wdata_i,
    input  logic [NumBanks*DataWidth/8-1:0]   mem_strb_i,
    input  logic [NumBanks-1:0]               mem_we_i,
    output logic [NumBanks-1:0]               mem_rvalid_o,
    output logic [NumBanks*DataWidth-1:0]     mem_rdata_o,
    output logic [NumBanks*2-1:0]             bank_state_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        bank_state_e state;

        sram_bank_ctrl_bank #(
            .WordsPerBank  (WordsPerBank),
            .DataWidth     (DataWidth),
            .ReadLatency   (ReadLatency),
            .IdleThreshold (IdleThreshold),
            .WakeCycles    (WakeCycles),
            .BankAddrWidth (BankAddrWidth)
        ) u_bank (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .ret_en_i (ret_en_i),
            .req_i    (mem_req_i[b]),
            .gnt_o    (mem_gnt_o[b]),
            .addr_i   (mem_addr_i[b*BankAddrWidth +: BankAddrWidth]),
            .wdata_i  (mem_wdata_i[b*DataWidth +: DataWidth]),
            .strb_i   (mem_strb_i[b*StrbWidth +: StrbWidth]),
            .we_i     (mem_we_i[b]),
            .rvalid_o (mem_rvalid_o[b]),
            .rdata_o  (mem_rdata_o[b*DataWidth +: DataWidth]),
            .state_o  (state)
        );

        assign bank_state_o[b*2 +: 2] = state;
    end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Randomized bench for sram_bank_ctrl with a transaction-level reference model.
module tb_sram_bank_ctrl;

    localparam int NB  = 2;
    localparam int WPB = 64;
    localparam int DW  = 64;
    localparam int SW  = DW / 8;
    localparam int AW  = 6;
    localparam int RL  = 3;
    localparam int IT  = 64;
    localparam int WC  = 4;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic ret_en = 1'b0;

    logic          req_b   [NB];
    logic          we_b    [NB];
    logic [AW-1:0] addr_b  [NB];
    logic [DW-1:0] wdata_b [NB];
    logic [SW-1:0] strb_b  [NB];

    logic [NB-1:0]    mem_req, mem_we, gnt, rvalid;
    logic [NB*AW-1:0] mem_addr;
    logic [NB*DW-1:0] mem_wdata, rdata;
    logic [NB*SW-1:0] mem_strb;
    logic [NB*2-1:0]  bank_state;

    for (genvar g = 0; g < NB; g++) begin : g_pack
        assign mem_req[g]             = req_b[g];
        assign mem_we[g]              = we_b[g];
        assign mem_addr[g*AW +: AW]   = addr_b[g];
        assign mem_wdata[g*DW +: DW]  = wdata_b[g];
        assign mem_strb[g*SW +: SW]   = strb_b[g];
    end

    sram_bank_ctrl #(
        .NumBanks      (NB),
        .WordsPerBank  (WPB),
        .DataWidth     (DW),
        .ReadLatency   (RL),
        .IdleThreshold (IT),
        .WakeCycles    (WC)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .ret_en_i     (ret_en),
        .mem_req_i    (mem_req),
        .mem_gnt_o    (gnt),
        .mem_addr_i   (mem_addr),
        .mem_wdata_i  (mem_wdata),
        .mem_strb_i   (mem_strb),
        .mem_we_i     (mem_we),
        .mem_rvalid_o (rvalid),
        .mem_rdata_o  (rdata),
        .bank_state_o (bank_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int xfer_cyc [NB];
    int burst_first [NB];
    bit burst_reads [NB];
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pat(input int b, input int i);
        return {32'hA5A5_0000 + 32'(b), 32'h0000_1000 + 32'(i)};
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        bit          rd;
        bit          known;
        logic [63:0] data;
    } resp_t;

    resp_t       rq [NB][$];
    logic [63:0] mem_m   [NB][WPB];
    bit          known_m [NB][WPB];
    int          streak    [NB];
    bit          asleep    [NB];
    int          wake_left [NB];

    always @(negedge clk) begin : cmp
        bit    eg, pend, ev, idle;
        int    es, a;
        resp_t r;
        if (!rst_ni) begin
            chk("rst_gnt", 64'(gnt), 64'({NB{1'b1}}));
            chk("rst_rvalid", 64'(rvalid), 64'd0);
            chk("rst_state", 64'(bank_state), 64'd0);
            for (int b = 0; b < NB; b++) begin
                chk($sformatf("rst_rdata%0d", b), rdata[b*DW +: DW], 64'd0);
                streak[b] = 0;
                asleep[b] = 0;
                wake_left[b] = 0;
                rq[b].delete();
                for (int k = 0; k < WPB; k++) known_m[b][k] = 0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                eg   = !asleep[b] && (wake_left[b] == 0);
                es   = asleep[b] ? 1 : ((wake_left[b] > 0) ? 2 : 0);
                pend = rq[b].size() > 0;
                ev   = pend && (rq[b][0].due == cyc);
                chk($sformatf("gnt%0d", b), 64'(gnt[b]), 64'(eg));
                chk($sformatf("state%0d", b), 64'(bank_state[b*2 +: 2]), 64'(es));
                chk($sformatf("rvalid%0d", b), 64'(rvalid[b]), 64'(ev));
                if (ev) begin
                    r = rq[b].pop_front();
                    if (r.rd && r.known)
                        chk($sformatf("rdata%0d", b), rdata[b*DW +: DW], r.data);
                end
                if (req_b[b] && eg) begin
                    a       = int'(addr_b[b]);
                    r.due   = cyc + RL;
                    r.rd    = !we_b[b];
                    r.known = known_m[b][a];
                    r.data  = mem_m[b][a];
                    if (we_b[b]) begin
                        for (int k = 0; k < SW; k++)
                            if (strb_b[b][k]) mem_m[b][a][k*8 +: 8] = wdata_b[b][k*8 +: 8];
                        if (strb_b[b] == '1) known_m[b][a] = 1;
                    end
                    rq[b].push_back(r);
                end
                if (asleep[b]) begin
                    if (req_b[b] || !ret_en) begin
                        asleep[b]    = 0;
                        wake_left[b] = WC;
                    end
                end else if (wake_left[b] > 0) begin
                    wake_left[b]--;
                end else begin
                    idle = !req_b[b] && !pend;
                    if (ret_en && IT != 0 && idle && streak[b] >= IT - 1) begin
                        asleep[b] = 1;
                        streak[b] = 0;
                    end else begin
                        streak[b] = idle ? streak[b] + 1 : 0;
                    end
                end
            end
        end
    end

    // ---------------- drivers (called just after a rising edge) ----------------
    task automatic xfer(input int b, input bit we, input int a,
                        input logic [63:0] d, input logic [SW-1:0] s);
        int n;
        req_b[b] = 1'b1; we_b[b] = we; addr_b[b] = AW'(a); wdata_b[b] = d; strb_b[b] = s;
        n = 0;
        @(negedge clk);
        while (!gnt[b] && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk($sformatf("gnt_wait%0d", b), 64'(gnt[b]), 64'd1);
        xfer_cyc[b] = cyc;
        @(posedge clk); #1;
    endtask

    task automatic idle_n(input int b, input int n);
        req_b[b] = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic read_check(input int b, input int a, input logic [63:0] exp, input string name);
        xfer(b, 1'b0, a, '0, '0);
        req_b[b] = 1'b0;
        repeat (RL) @(negedge clk);
        chk({name, "_rvalid"}, 64'(rvalid[b]), 64'd1);
        chk({name, "_rdata"}, rdata[b*DW +: DW], exp);
        @(posedge clk); #1;
    endtask

    task automatic burst(input int b);
        for (int i = 0; i < 8; i++) xfer(b, 1'b1, i, pat(b, i), '1);
        idle_n(b, 5);
        burst_reads[b] = 1;
        for (int i = 0; i < 8; i++) begin
            xfer(b, 1'b0, i, '0, '0);
            if (i == 0) burst_first[b] = xfer_cyc[b];
        end
        req_b[b] = 1'b0;
    endtask

    task automatic sweep_mon(input int b);
        int n;
        n = 0;
        @(negedge clk);
        while (!(burst_reads[b] && rvalid[b]) && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("sweep_first_latency", 64'(cyc), 64'(burst_first[b] + RL));
        for (int i = 0; i < 8; i++) begin
            chk("sweep_rvalid", 64'(rvalid[b]), 64'd1);
            chk("sweep_rdata", rdata[b*DW +: DW], pat(b, i));
            chk("sweep_gnt", 64'(gnt[b]), 64'd1);
            @(negedge clk);
        end
        chk("sweep_end", 64'(rvalid[b]), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic ret_mon();
        int n, k;
        n = 0;
        k = 0;
        @(negedge clk);
        while (bank_state[3:2] != 2'd1 && k < 300) begin
            if (rvalid[1] || req_b[1]) n = 0;
            else n++;
            k++;
            @(negedge clk);
        end
        chk("ret_idle_cycles", 64'(n), 64'd64);
        chk("ret_state1", 64'(bank_state[3:2]), 64'd1);
        chk("ret_state0_busy", 64'(bank_state[1:0]), 64'd0);
    endtask

    task automatic rand_drv(input int b);
        int r;
        for (int t = 0; t < 250; t++) begin
            r = int'($urandom % 20);
            if (r == 0) idle_n(b, int'($urandom_range(55, 90)));
            else if (r < 6) idle_n(b, int'($urandom_range(1, 3)));
            xfer(b, 1'($urandom % 2), int'($urandom_range(0, 15)),
                 {$urandom, $urandom}, SW'($urandom));
        end
        req_b[b] = 1'b0;
        done_cnt++;
    endtask

    initial begin : watchdog
        #1_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin : main
        int w;
        for (int b = 0; b < NB; b++) begin
            req_b[b] = 0; we_b[b] = 0; addr_b[b] = '0; wdata_b[b] = '0; strb_b[b] = '0;
            burst_reads[b] = 0; burst_first[b] = 0; xfer_cyc[b] = 0;
        end
        repeat (3) @(negedge clk);
        chk("reset_gnt", 64'(gnt), 64'h3);
        chk("reset_state", 64'(bank_state), 64'h0);
        @(posedge clk); #1;
        rst_ni = 1'b1;

        // write then read
        xfer(0, 1'b1, 5, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        read_check(0, 5, 64'hDEADBEEF_CAFEF00D, "wr_rd");

        // partial write
        xfer(0, 1'b1, 7, 64'h11223344_55667788, 8'hFF);
        xfer(0, 1'b1, 7, 64'hFFFFFFFF_FFFFFFFF, 8'h0F);
        read_check(0, 7, 64'h11223344_FFFFFFFF, "partial");

        // back-to-back bursts on both banks
        fork
            burst(0);
            burst(1);
            sweep_mon(1);
        join

        // retention entry on idle bank1 while bank0 stays busy
        ret_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    xfer(0, 1'b0, i % 8, '0, '0);
                    idle_n(0, 1);
                end
            end
            begin
                xfer(1, 1'b0, 2, '0, '0);
                req_b[1] = 1'b0;
                ret_mon();
            end
        join
        @(posedge clk); #1;

        // wake from retention on a read
        req_b[1] = 1'b1; we_b[1] = 1'b0; addr_b[1] = AW'(3);
        @(negedge clk);
        chk("wake_start_state", 64'(bank_state[3:2]), 64'd1);
        chk("wake_start_gnt", 64'(gnt[1]), 64'd0);
        w = 0;
        @(negedge clk);
        while (bank_state[3:2] == 2'd2 && w < 20) begin
            chk("wake_gnt_low", 64'(gnt[1]), 64'd0);
            w++;
            @(negedge clk);
        end
        chk("wake_cycles", 64'(w), 64'd4);
        chk("wake_gnt", 64'(gnt[1]), 64'd1);
        @(posedge clk); #1;
        req_b[1] = 1'b0;
        repeat (RL) @(negedge clk);
        chk("wake_rvalid", 64'(rvalid[1]), 64'd1);
        chk("wake_rdata", rdata[DW +: DW], pat(1, 3));
        @(posedge clk); #1;

        // dropping ret_en wakes retained banks without a request
        idle_n(0, 80);
        chk("ret_both0", 64'(bank_state[1:0]), 64'd1);
        chk("ret_both1", 64'(bank_state[3:2]), 64'd1);
        ret_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("reten_drop0", 64'(bank_state[1:0]), 64'd2);
        chk("reten_drop1", 64'(bank_state[3:2]), 64'd2);
        @(posedge clk); #1;
        idle_n(0, 10);

        // random traffic with ret_en toggling
        fork
            for (int i = 8; i < 16; i++) xfer(0, 1'b1, i, {$urandom, $urandom}, '1);
            for (int i = 8; i < 16; i++) xfer(1, 1'b1, i, {$urandom, $urandom}, '1);
        join
        req_b[0] = 1'b0;
        req_b[1] = 1'b0;
        fork
            rand_drv(0);
            rand_drv(1);
            begin
                for (int k = 0; k < 20000 && done_cnt < 2; k++) begin
                    @(posedge clk); #1;
                    if ($urandom % 150 == 0) ret_en = ~ret_en;
                end
            end
        join

        // reset one cycle after a granted read
        ret_en = 1'b0;
        idle_n(0, 10);
        xfer(0, 1'b0, 5, '0, '0);
        req_b[0] = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("midrst_gnt", 64'(gnt), 64'h3);
        chk("midrst_rvalid", 64'(rvalid), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(negedge clk);
        chk("postrst_state", 64'(bank_state), 64'h0);
        chk("postrst_gnt", 64'(gnt), 64'h3);
        for (int i = 0; i < 6; i++) begin
            chk("postrst_no_rvalid", 64'(rvalid), 64'h0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_bank_ctrl.md
Name: sram_bank_ctrl

Overview:
- Multi-bank SRAM back end behind the AXI-to-memory converter, configured with NumBanks>1; it is the parametrised successor of the single-bank, fixed-latency, always-granted memory subsystem.
- Instantiates one sram_wrapper per bank and passes byte strobes through, so partial writes are honoured.
- Read latency is configurable.
- Each bank has an idle-driven retention state machine: a bank enters retention after a programmable number of idle cycles, and a request wakes it by stalling the grant.

Parameters:
- NumBanks, 2, number of independent SRAM banks (power of two, ≥1).
- WordsPerBank, 4096, 64-bit words per bank.
- DataWidth, 64, word width in bits (multiple of 8).
- ReadLatency, 1, cycles from granted request to mem_rvalid_o (1..4).
- IdleThreshold, 64, consecutive idle cycles before retention entry (0 = retention disabled).
- WakeCycles, 4, grant-stall cycles when leaving retention (≥1).
- BankAddrWidth, $clog2(WordsPerBank), derived; per-bank word address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- ret_en_i  in  1  global retention enable.
- mem_req_i  in  NumBanks  per-bank request.
- mem_gnt_o  out  NumBanks  per-bank grant.
- mem_addr_i  in  NumBanks×BankAddrWidth  per-bank word address.
- mem_wdata_i  in  NumBanks×DataWidth  write data.
- mem_strb_i  in  NumBanks×DataWidth/8  byte enables.
- mem_we_i  in  NumBanks  write enable.
- mem_rvalid_o  out  NumBanks  response valid (reads and writes).
- mem_rdata_o  out  NumBanks×DataWidth  read data.
- bank_state_o  out  NumBanks×2  per-bank FSM state (ACTIVE=0, RETENTION=1, WAKE=2).

Behaviour:
- Reset is asynchronous and active-low.
- Reset values:
  - gnt = all 1s (every bank ACTIVE).
  - rvalid = 0, rdata = 0.
  - bank_state = ACTIVE.
  - Idle counters = 0, wake counters = 0.
- Banks are fully independent. There is no cross-bank arbitration, and simultaneous requests to all banks all proceed in the same cycle.
- Handshake:
  - A transfer occurs when req && gnt. The SRAM is accessed that cycle with req/we/addr/wdata/strb (be_i = strb).
  - While gnt=0, the requester holds req and its payload stable.
- Response:
  - rvalid pulses exactly ReadLatency cycles after each transfer, one pulse per transfer, in order.
  - Back-to-back transfers give back-to-back rvalid, with a throughput of 1 per bank per cycle.
  - rdata holds the SRAM word for reads and is don't-care for writes.
  - ReadLatency>1 adds ReadLatency−1 register stages on both rdata and the valid shift register.
- Write semantics: only bytes with strb=1 are modified. A read of the same address in the next cycle returns the merged word.
- FSM per bank:
  - ACTIVE: gnt=1, set_retentive_n=1.
    - The idle counter increments on each cycle with no req and no rvalid pipeline bit set, and clears otherwise.
    - If ret_en_i && IdleThreshold≠0 && counter==IdleThreshold−1 && !req, go to RETENTION and clear the counter.
  - RETENTION: gnt=0, SRAM set_retentive_n=0, SRAM req forced 0.
    - If req || !ret_en_i, go to WAKE and load the wake counter with WakeCycles−1.
  - WAKE: gnt=0, set_retentive_n=1.
    - The wake counter decrements; at 0, go to ACTIVE. The first grant arrives in the cycle after the counter reaches 0.
- Retention is never entered while a response is pending in the pipeline.
- The idle counter saturates and never wraps.
- ret_en_i deasserted while in RETENTION wakes the bank even with no request.
- pwrgate_ni is tied to 1 (no power gating in this generation).
- Reset asserted mid-operation: outputs return to their reset values asynchronously, in-flight rvalids are dropped, and SRAM contents are undefined.

Decomposition:
- Shared package sram_bank_pkg:
  - bank_state_e enum, 2 bits: ACTIVE, RETENTION, WAKE.
  - Latency bounds constants: MaxReadLatency=4.
- Sub-module sram_bank_ctrl_bank: one bank's FSM, idle/wake counters, latency pipeline and sram_wrapper instance.
- The top level is a generate loop over NumBanks plus port flattening.

Test Plan:
- Write then read, ReadLatency=1:
  - Write 0xDEADBEEF_CAFEF00D to bank0 addr 5, strb=0xFF, then read addr 5.
  - Required: rvalid on cycle t+1 for each transfer; rdata=0xDEADBEEF_CAFEF00D.
- Partial write:
  - Preload 0x11223344_55667788, then write 0xFFFFFFFF_FFFFFFFF with strb=0x0F.
  - Required: the read returns 0x11223344_FFFFFFFF.
- Latency sweep:
  - ReadLatency=3, 8 back-to-back reads on both banks simultaneously.
  - Required: 8 consecutive rvalid pulses starting 3 cycles after the first grant, data in order, gnt stays 1.
- Retention entry:
  - IdleThreshold=64, ret_en_i=1, bank1 idle.
  - Required: bank_state_o[1]=RETENTION after exactly 64 idle cycles; bank0 stays ACTIVE while it has traffic.
- Wake:
  - Issue a read to bank1 in RETENTION with WakeCycles=4.
  - Required: WAKE for 4 cycles with gnt=0, then gnt=1, rvalid ReadLatency later, and previously written data intact.
- Reset mid-read:
  - Assert rst_ni low one cycle after a granted read with ReadLatency=2.
  - Required: rvalid never pulses, all banks ACTIVE, gnt=1 after release.
